// File: rtl/e_mdu_pkg.sv
// Shared CPU constants for the multiply/divide unit: op encodings and default latencies.
// The controller and the D-stage hazard logic use the same definitions.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdop_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Result packs HI in [63:32] and LO in [31:0].
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [3:0]  mdop_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic        ovf;
  logic [31:0] s_divisor;
  logic [31:0] u_divisor;
  logic [63:0] s_prod;
  logic [63:0] u_prod;
  logic signed [31:0] s_quot;
  logic signed [31:0] s_rem;
  logic [31:0] u_quot;
  logic [31:0] u_rem;

  assign div_zero_o = (rt_i == 32'd0);
  assign ovf        = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

  // Substituting 1 for the divisor yields 0x80000000 r 0 for the overflow case
  // and keeps the divider defined for zero divisors.
  assign s_divisor = (div_zero_o || ovf) ? 32'd1 : rt_i;
  assign u_divisor = div_zero_o ? 32'd1 : rt_i;

  assign s_prod = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign u_prod = {32'd0, rs_i} * {32'd0, rt_i};

  assign s_quot = $signed(rs_i) / $signed(s_divisor);
  assign s_rem  = $signed(rs_i) % $signed(s_divisor);
  assign u_quot = rs_i / u_divisor;
  assign u_rem  = rs_i % u_divisor;

  always_comb begin
    result_o = 64'd0;
    case (mdop_e'(mdop_i))
      MD_MULT:  result_o = s_prod;
      MD_MULTU: result_o = u_prod;
      MD_DIV:   result_o = div_zero_o ? 64'd0 : {s_rem, s_quot};
      MD_DIVU:  result_o = div_zero_o ? 64'd0 : {u_rem, u_quot};
      default:  result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy counter and
// mfhi/mflo read port. Results are computed at acceptance and committed on completion.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          commit_q, commit_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   arith_result;
  logic          div_zero;

  e_mdu_arith u_arith (
    .mdop_i     (mdop),
    .rs_i       (rs_data),
    .rt_i       (rt_data),
    .result_o   (arith_result),
    .div_zero_o (div_zero)
  );

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // While counting, start is ignored; a zero-divisor op runs the full period
  // but its commit flag is clear so HI/LO keep their old values.
  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE && commit_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (start) begin
      case (mdop_e'(mdop))
        MD_MULT, MD_MULTU: begin
          pend_d   = arith_result;
          commit_d = 1'b1;
          cnt_d    = MULT_LOAD;
        end
        MD_DIV, MD_DIVU: begin
          pend_d   = arith_result;
          commit_d = ~div_zero;
          cnt_d    = DIV_LOAD;
        end
        MD_MTHI: hi_d = rs_data;
        MD_MTLO: lo_d = rs_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      pend_q   <= 64'd0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    md_out = 32'd0;
    case (mdop_e'(mdop))
      MD_MFHI: md_out = hi_q;
      MD_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO for each long op,
// a monitor pops and compares whenever busy falls.
module tb_e_mdu;
   import e_mdu_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdop;
   logic [31:0] rsData;
   logic [31:0] rtData;
   logic        busy;
   logic [31:0] mdOut;
   logic [31:0] hiOut;
   logic [31:0] loOut;

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] sbQ[$];
   logic [63:0] monExp;
   logic [31:0] mHi = 32'd0;
   logic [31:0] mLo = 32'd0;
   logic        monEnable = 1'b0;
   logic        prevBusy = 1'b0;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdop    (mdop),
      .rs_data (rsData),
      .rt_data (rtData),
      .busy    (busy),
      .md_out  (mdOut),
      .hi      (hiOut),
      .lo      (loOut)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard time limit so a stuck DUT can never hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a failure line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference arithmetic straight from the MIPS definitions using 64-bit integers
   function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      case (op)
         4'(MD_MULT):  return sa * sb;
         4'(MD_MULTU): return ua * ub;
         4'(MD_DIV):   return {32'(sa % sb), 32'(sa / sb)};
         4'(MD_DIVU):  return {32'(ua % ub), 32'(ua / ub)};
         default:      return 64'd0;
      endcase
   endfunction

   // Monitor: each busy falling edge is a completion and must match the oldest expectation
   always @(negedge clk) begin
      if (monEnable && prevBusy && !busy) begin
         if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL completion: got busy fall expected none pending");
         end else begin
            monExp = sbQ.pop_front();
            checkOutput("hi_commit", hiOut, monExp[63:32]);
            checkOutput("lo_commit", loOut, monExp[31:0]);
         end
      end
      prevBusy = busy;
   end

   // Presents one op for exactly one clock edge; returns #1 into the following cycle
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      mdop   = op;
      rsData = a;
      rtData = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      mdop  = 4'(MD_NONE);
   endtask

   // Counts busy cycles from the current cycle with a bounded wait
   task automatic waitIdle(input string name, input int expCycles);
      int n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput(name, 32'(n), 32'(expCycles));
      @(posedge clk);
      #1;
   endtask

   // Reads both registers through md_out and directly
   task automatic mfCheck();
      mdop = 4'(MD_MFLO);
      @(negedge clk);
      checkOutput("mflo", mdOut, mLo);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      mdop = 4'(MD_MFHI);
      @(negedge clk);
      checkOutput("mfhi", mdOut, mHi);
      checkOutput("hi_reg", hiOut, mHi);
      checkOutput("lo_reg", loOut, mLo);
      @(posedge clk);
      #1;
      mdop = 4'(MD_NONE);
   endtask

   // Issues an op on an idle unit and updates the model and scoreboard
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      applyStimulus(op, a, b);
      if (op == 4'(MD_MULT) || op == 4'(MD_MULTU)) begin
         r = refResult(op, a, b);
         sbQ.push_back(r);
         mHi = r[63:32];
         mLo = r[31:0];
         waitIdle("mult_busy_cycles", MC);
      end else if (op == 4'(MD_DIV) || op == 4'(MD_DIVU)) begin
         if (b == 32'd0) begin
            sbQ.push_back({mHi, mLo});
         end else begin
            r = refResult(op, a, b);
            sbQ.push_back(r);
            mHi = r[63:32];
            mLo = r[31:0];
         end
         waitIdle("div_busy_cycles", DC);
      end else begin
         if (op == 4'(MD_MTHI)) mHi = a;
         else if (op == 4'(MD_MTLO)) mLo = a;
         waitIdle("no_busy_cycles", 0);
      end
      mfCheck();
   endtask

   initial begin
      int highs;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] r;

      reset  = 1'b1;
      start  = 1'b0;
      mdop   = 4'(MD_NONE);
      rsData = 32'd0;
      rtData = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mdop  = 4'(MD_MFHI);
      @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_hi", hiOut, 32'd0);
      checkOutput("reset_lo", loOut, 32'd0);
      checkOutput("reset_md_out", mdOut, 32'd0);
      monEnable = 1'b1;
      @(posedge clk);
      #1;
      mdop = 4'(MD_NONE);

      $display("[TB] directed mult/div cases");
      runOp(4'(MD_MULT), 32'hFFFF_FFFE, 32'd3);
      checkOutput("mult_hi_const", hiOut, 32'hFFFF_FFFF);
      checkOutput("mult_lo_const", loOut, 32'hFFFF_FFFA);
      runOp(4'(MD_MULTU), 32'hFFFF_FFFE, 32'd3);
      checkOutput("multu_hi_const", hiOut, 32'h0000_0002);
      checkOutput("multu_lo_const", loOut, 32'hFFFF_FFFA);
      runOp(4'(MD_DIV), 32'hFFFF_FFF9, 32'd2);
      checkOutput("div_hi_const", hiOut, 32'hFFFF_FFFF);
      checkOutput("div_lo_const", loOut, 32'hFFFF_FFFD);
      runOp(4'(MD_DIVU), 32'd7, 32'd2);
      checkOutput("divu_hi_const", hiOut, 32'd1);
      checkOutput("divu_lo_const", loOut, 32'd3);

      $display("[TB] divide by zero and overflow");
      runOp(4'(MD_MTHI), 32'h11, 32'd0);
      runOp(4'(MD_MTLO), 32'h22, 32'd0);
      runOp(4'(MD_DIV), 32'd5, 32'd0);
      checkOutput("divzero_hi_const", hiOut, 32'h11);
      checkOutput("divzero_lo_const", loOut, 32'h22);
      runOp(4'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("divovf_hi_const", hiOut, 32'd0);
      checkOutput("divovf_lo_const", loOut, 32'h8000_0000);

      $display("[TB] start while busy");
      applyStimulus(4'(MD_MULT), 32'h1234_5678, 32'h9ABC_DEF0);
      r = refResult(4'(MD_MULT), 32'h1234_5678, 32'h9ABC_DEF0);
      sbQ.push_back(r);
      mHi = r[63:32];
      mLo = r[31:0];
      @(posedge clk);
      #1;
      start  = 1'b1;
      mdop   = 4'(MD_MTHI);
      rsData = 32'hAB;
      @(posedge clk);
      #1;
      start = 1'b0;
      mdop  = 4'(MD_NONE);
      waitIdle("busy_after_ignored_start", MC - 2);
      mfCheck();

      $display("[TB] mtlo then mflo");
      applyStimulus(4'(MD_MTLO), 32'h1234, 32'd0);
      mLo  = 32'h1234;
      mdop = 4'(MD_MFLO);
      @(negedge clk);
      checkOutput("mtlo_mflo", mdOut, 32'h1234);
      checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      mdop = 4'(MD_NONE);

      $display("[TB] reset mid divide");
      applyStimulus(4'(MD_DIV), 32'd100, 32'd7);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      sbQ.delete();
      sbQ.push_back(64'd0);
      mHi   = 32'd0;
      mLo   = 32'd0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_hi", hiOut, 32'd0);
      checkOutput("abort_lo", loOut, 32'd0);
      highs = 0;
      repeat (DC + 2) begin
         @(negedge clk);
         if (busy !== 1'b0) highs++;
      end
      checkOutput("abort_busy_later", 32'(highs), 32'd0);
      checkOutput("abort_hi_later", hiOut, 32'd0);
      checkOutput("abort_lo_later", loOut, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] random ops");
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 8));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
         runOp(op, a, b);
      end

      repeat (2) @(posedge clk);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
